// File: rtl/riscv_cpu_pkg.sv
// Shared types and defaults for the EX-stage control slice.
// Holds the EX FSM state encoding and the default multi-cycle counter width.
package riscv_cpu_pkg;

  localparam int MC_CNT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    EXEC  = 2'd2
  } ex_ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/ex_ctrl.sv
// EX-stage handshake controller: accept/stall, multi-cycle wait, branch flush.
// Also counts decode-side stall cycles for performance monitoring.
//
// state | meaning
// IDLE  | EX empty, ready for a new instruction
// MULTI | multi-cycle op in progress, latency counter running
// EXEC  | EX holds a valid result, waiting for MEM to take it
module ex_ctrl
  import riscv_cpu_pkg::*;
#(
  parameter int MC_CNT_WIDTH = MC_CNT_WIDTH_DEFAULT,
  parameter int PERF_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    id_valid_i,
  output logic                    id_ready_o,
  input  logic                    multicycle_i,
  input  logic [MC_CNT_WIDTH-1:0] mc_latency_i,
  input  logic                    branch_taken_i,
  input  logic                    mem_ready_i,
  output logic                    ex_en_o,
  output logic                    ex_valid_o,
  output logic                    if_flush_o,
  output logic                    busy_o,
  input  logic                    perf_clr_i,
  output logic [PERF_WIDTH-1:0]   stall_cnt_o
);

  localparam logic [MC_CNT_WIDTH-1:0] CNT_ONE = MC_CNT_WIDTH'(1);

  ex_ctrl_state_e state, state_n;
  logic [MC_CNT_WIDTH-1:0] cnt, cnt_n;
  logic accept;
  logic ex_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    ex_en      = 1'b0;
    id_ready_o = 1'b0;
    ex_valid_o = 1'b0;
    if_flush_o = 1'b0;
    busy_o     = 1'b0;

    case (state)
      IDLE: begin
        id_ready_o = 1'b1;
        accept     = id_valid_i;
      end
      MULTI: begin
        busy_o = 1'b1;
        cnt_n  = cnt - 1'b1;
        if (cnt <= CNT_ONE) begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        ex_valid_o = 1'b1;
        if (mem_ready_i) begin
          state_n = IDLE;
          if (branch_taken_i) begin
            // wrong-path instruction on the ID side is dropped, never accepted
            if_flush_o = 1'b1;
          end else begin
            id_ready_o = 1'b1;
            accept     = id_valid_i;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // a zero latency multi-cycle op behaves exactly like a single-cycle one
    if (accept) begin
      ex_en = 1'b1;
      if (multicycle_i && (mc_latency_i != '0)) begin
        state_n = MULTI;
        cnt_n   = mc_latency_i;
      end else begin
        state_n = EXEC;
      end
    end
  end

  assign ex_en_o = ex_en & ~rst_i;

  sat_counter #(
    .WIDTH (PERF_WIDTH)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (id_valid_i & ~id_ready_o),
    .clr_i (perf_clr_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_ex_ctrl.sv
// Directed bench for ex_ctrl: a default instance plus a PERF_WIDTH=4 instance
// sharing one stimulus stream, with hand-computed expectations.
module tb_ex_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic        multicycle_i;
  logic [3:0]  mc_latency_i;
  logic        branch_taken_i;
  logic        mem_ready_i;
  logic        perf_clr_i;

  logic        id_ready, ex_en, ex_valid, if_flush, busy;
  logic [15:0] stall_cnt;
  logic        id_ready_s, ex_en_s, ex_valid_s, if_flush_s, busy_s;
  logic [3:0]  stall_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ex_ctrl u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_ready_o     (id_ready),
    .multicycle_i   (multicycle_i),
    .mc_latency_i   (mc_latency_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .ex_en_o        (ex_en),
    .ex_valid_o     (ex_valid),
    .if_flush_o     (if_flush),
    .busy_o         (busy),
    .perf_clr_i     (perf_clr_i),
    .stall_cnt_o    (stall_cnt)
  );

  ex_ctrl #(.PERF_WIDTH(4)) u_dut_sat (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_ready_o     (id_ready_s),
    .multicycle_i   (multicycle_i),
    .mc_latency_i   (mc_latency_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .ex_en_o        (ex_en_s),
    .ex_valid_o     (ex_valid_s),
    .if_flush_o     (if_flush_s),
    .busy_o         (busy_s),
    .perf_clr_i     (perf_clr_i),
    .stall_cnt_o    (stall_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic mc, input logic [3:0] lat,
                       input logic mr, input logic br);
    id_valid_i     = v;
    multicycle_i   = mc;
    mc_latency_i   = lat;
    mem_ready_i    = mr;
    branch_taken_i = br;
    #1;
  endtask

  task automatic clear_perf();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    #1;
    check("perf_clr", 32'(stall_cnt), 0);
  endtask

  initial begin
    rst_i = 1'b1;
    perf_clr_i = 1'b0;
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    #2;
    check("rst ex_en", 32'(ex_en), 0);
    check("rst ex_valid", 32'(ex_valid), 0);
    check("rst if_flush", 32'(if_flush), 0);
    check("rst busy", 32'(busy), 0);
    check("rst stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("post-rst id_ready", 32'(id_ready), 1);
    tick();

    // three back-to-back single-cycle instructions
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    check("b2b t ex_en", 32'(ex_en), 1);
    check("b2b t ex_valid", 32'(ex_valid), 0);
    tick();
    check("b2b t+1 ex_valid", 32'(ex_valid), 1);
    check("b2b t+1 ex_en", 32'(ex_en), 1);
    tick();
    check("b2b t+2 ex_valid", 32'(ex_valid), 1);
    check("b2b t+2 ex_en", 32'(ex_en), 1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("b2b t+3 ex_valid", 32'(ex_valid), 1);
    check("b2b t+3 ex_en", 32'(ex_en), 0);
    tick();
    check("b2b t+4 ex_valid", 32'(ex_valid), 0);
    check("b2b stall_cnt", 32'(stall_cnt), 0);

    // multi-cycle latency 3, next instruction held valid behind it
    drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    check("mc t ex_en", 32'(ex_en), 1);
    tick();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("mc t+%0d busy", i), 32'(busy), 1);
      check($sformatf("mc t+%0d id_ready", i), 32'(id_ready), 0);
      check($sformatf("mc t+%0d ex_valid", i), 32'(ex_valid), 0);
      tick();
    end
    check("mc t+4 ex_valid", 32'(ex_valid), 1);
    check("mc t+4 busy", 32'(busy), 0);
    check("mc stall_cnt", 32'(stall_cnt), 3);
    check("mc t+4 ex_en", 32'(ex_en), 1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("mc 2nd ex_valid", 32'(ex_valid), 1);
    tick();
    check("mc idle ex_valid", 32'(ex_valid), 0);

    // multicycle with zero latency is single-cycle
    drive(1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("lat0 busy", 32'(busy), 0);
    check("lat0 ex_valid", 32'(ex_valid), 1);
    tick();

    // taken branch in EXEC with a pending instruction
    clear_perf();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("br if_flush", 32'(if_flush), 1);
    check("br id_ready", 32'(id_ready), 0);
    check("br ex_en", 32'(ex_en), 0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("br+1 if_flush", 32'(if_flush), 0);
    check("br+1 ex_valid", 32'(ex_valid), 0);
    check("br+1 id_ready", 32'(id_ready), 1);
    check("br stall_cnt", 32'(stall_cnt), 1);
    tick();

    // MEM back-pressure for 4 cycles
    clear_perf();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp %0d ex_valid", i), 32'(ex_valid), 1);
      check($sformatf("bp %0d ex_en", i), 32'(ex_en), 0);
      check($sformatf("bp %0d if_flush", i), 32'(if_flush), 0);
      tick();
    end
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    check("bp stall_cnt", 32'(stall_cnt), 4);
    check("bp release ex_en", 32'(ex_en), 1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();

    // 20-cycle stall: 4-bit counter saturates, clear beats increment
    clear_perf();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (20) tick();
    check("sat4 stall_cnt", 32'(stall_cnt_s), 15);
    check("sat16 stall_cnt", 32'(stall_cnt), 20);
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    #1;
    check("clr prio sat4", 32'(stall_cnt_s), 0);
    check("clr prio sat16", 32'(stall_cnt), 0);
    tick();
    check("after clr sat4", 32'(stall_cnt_s), 1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();

    // reset in the middle of a latency-5 op
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    check("pre-rst busy", 32'(busy), 1);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    rst_i = 1'b1;
    #1;
    check("mid rst busy", 32'(busy), 0);
    check("mid rst ex_en", 32'(ex_en), 0);
    check("mid rst stall_cnt", 32'(stall_cnt), 0);
    check("mid rst stall_cnt4", 32'(stall_cnt_s), 0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    rst_i = 1'b0;
    #1;
    check("rel id_ready", 32'(id_ready), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rel %0d ex_valid", i), 32'(ex_valid), 0);
      check($sformatf("rel %0d busy", i), 32'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
